// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I control FSM: sequences fetch/decode/execute/memory/writeback with a
// req/ready memory handshake and wait timeout. Optional feature macro: CTRL_ILLEGAL_TRAP_EN.
module multicycle_ctrl_fsm #(
    parameter int ALUCTRL_W = 3,
    parameter int TIMEOUT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 adr_src,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 reg_write,
    output logic [1:0]           alu_src_a,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           result_src,
    output logic [2:0]           imm_src,
    output logic [ALUCTRL_W-1:0] alu_ctrl,
    output logic                 bus_err
`ifdef CTRL_ILLEGAL_TRAP_EN
    ,
    output logic                 illegal_instr
`endif
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_AND   = 3'b010;
    localparam logic [2:0] ALU_OR    = 3'b011;
    localparam logic [2:0] ALU_XOR   = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;
    localparam logic [2:0] ALU_PASSB = 3'b110;

    localparam logic [TIMEOUT_W-1:0] CNT_ALL1 = '1;
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = CNT_ALL1 - TIMEOUT_W'(1);

    // S_TRAP is only reachable when the illegal-instruction trap is built in.
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_MEMWB  = 4'd5,
        S_EXEC_R = 4'd6,
        S_EXEC_I = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JAL    = 4'd10,
        S_LUI    = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    state_t               state_r;
    state_t               state_next_s;
    logic [TIMEOUT_W-1:0] cnt_r;
    logic                 bus_err_r;
    logic                 wait_state_s;
    logic                 timeout_s;
    logic [2:0]           alu_code_s;

    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_ok);
        logic [2:0] code;
        case (f3)
            3'b000:  code = sub_ok ? ALU_SUB : ALU_ADD;
            3'b010:  code = ALU_SLT;
            3'b100:  code = ALU_XOR;
            3'b110:  code = ALU_OR;
            3'b111:  code = ALU_AND;
            default: code = ALU_ADD;
        endcase
        return code;
    endfunction

    function automatic logic alu_f3_legal(input logic [2:0] f3);
        logic legal;
        case (f3)
            3'b000, 3'b010, 3'b100, 3'b110, 3'b111: legal = 1'b1;
            default:                                legal = 1'b0;
        endcase
        return legal;
    endfunction

    assign wait_state_s = (state_r == S_FETCH) || (state_r == S_MEMRD) || (state_r == S_MEMWR);
    assign timeout_s    = wait_state_s && !mem_ready && (cnt_r == CNT_LAST);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Memory wait counter and sticky bus error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r     <= '0;
            bus_err_r <= 1'b0;
        end else begin
            if (timeout_s) begin
                bus_err_r <= 1'b1;
            end
            if (timeout_s || (wait_state_s && mem_ready) || (state_next_s != state_r)) begin
                cnt_r <= '0;
            end else if (wait_state_s) begin
                cnt_r <= cnt_r + TIMEOUT_W'(1);
            end
        end
    end

    // Next-state decode; a timeout overrides every other transition.
    always_comb begin
        state_next_s = state_r;
        if (timeout_s) begin
            state_next_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH:  state_next_s = mem_ready ? S_DECODE : S_FETCH;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state_next_s = S_MEMADR;
                        OP_R:              state_next_s = S_EXEC_R;
                        OP_I:              state_next_s = S_EXEC_I;
                        OP_BRANCH:         state_next_s = S_BRANCH;
                        OP_JAL:            state_next_s = S_JAL;
                        OP_LUI:            state_next_s = S_LUI;
`ifdef CTRL_ILLEGAL_TRAP_EN
                        default:           state_next_s = S_TRAP;
`else
                        default:           state_next_s = S_FETCH;
`endif
                    endcase
                end
                S_MEMADR: state_next_s = (op == OP_STORE) ? S_MEMWR : S_MEMRD;
                S_MEMRD:  state_next_s = mem_ready ? S_MEMWB : S_MEMRD;
                S_MEMWR:  state_next_s = mem_ready ? S_FETCH : S_MEMWR;
                S_MEMWB:  state_next_s = S_FETCH;
`ifdef CTRL_ILLEGAL_TRAP_EN
                S_EXEC_R, S_EXEC_I: state_next_s = alu_f3_legal(funct3) ? S_ALUWB : S_TRAP;
                S_BRANCH: state_next_s = (funct3[2:1] == 2'b00) ? S_FETCH : S_TRAP;
                S_TRAP:   state_next_s = S_TRAP;
`else
                S_EXEC_R, S_EXEC_I: state_next_s = alu_f3_legal(funct3) ? S_ALUWB : S_ALUWB;
                S_BRANCH: state_next_s = S_FETCH;
                S_TRAP:   state_next_s = S_FETCH;
`endif
                S_ALUWB:  state_next_s = S_FETCH;
                S_JAL:    state_next_s = S_ALUWB;
                S_LUI:    state_next_s = S_ALUWB;
                default:  state_next_s = S_FETCH;
            endcase
        end
    end

    // Output decode; reset forces every enable low at once.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        result_src = 2'b00;
        imm_src    = 3'b000;
        alu_code_s = ALU_ADD;
        if (!rst) begin
            case (state_r)
                S_FETCH: begin
                    mem_req = 1'b1;
                    if (mem_ready) begin
                        ir_write   = 1'b1;
                        pc_write   = 1'b1;
                        alu_src_b  = 2'b10;
                        result_src = 2'b10;
                    end else begin
                        ir_write   = 1'b0;
                    end
                end
                S_DECODE: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b01;
                    imm_src   = 3'b010;
                end
                S_MEMADR: begin
                    alu_src_a = 2'b10;
                    alu_src_b = 2'b01;
                    imm_src   = (op == OP_STORE) ? 3'b001 : 3'b000;
                end
                S_MEMRD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWR: begin
                    mem_req = 1'b1;
                    mem_we  = 1'b1;
                    adr_src = 1'b1;
                end
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    result_src = 2'b01;
                end
                S_EXEC_R: begin
                    alu_src_a  = 2'b10;
                    alu_code_s = alu_decode(funct3, funct7b5);
                end
                S_EXEC_I: begin
                    alu_src_a  = 2'b10;
                    alu_src_b  = 2'b01;
                    alu_code_s = alu_decode(funct3, 1'b0);
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a  = 2'b10;
                    alu_code_s = ALU_SUB;
                    case (funct3)
                        3'b000:  pc_write = zero;
                        3'b001:  pc_write = ~zero;
                        default: pc_write = 1'b0;
                    endcase
                end
                S_JAL: begin
                    alu_src_a = 2'b01;
                    alu_src_b = 2'b10;
                    pc_write  = 1'b1;
                end
                S_LUI: begin
                    alu_src_b  = 2'b01;
                    imm_src    = 3'b100;
                    alu_code_s = ALU_PASSB;
                end
                default: begin
                    mem_req = 1'b0;
                end
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    assign alu_ctrl = ALUCTRL_W'(alu_code_s);
    assign bus_err  = bus_err_r;

`ifdef CTRL_ILLEGAL_TRAP_EN
    assign illegal_instr = (state_r == S_TRAP);
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Randomized bench for multicycle_ctrl_fsm: a per-instruction model expands each instruction
// into its expected cycle-by-cycle control vectors and the bench replays them against the DUT.
module tb_multicycle_ctrl_fsm;

    localparam int TW   = 3;
    localparam int TMAX = (1 << TW) - 1;

    localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011, RTYPE = 7'b0110011;
    localparam logic [6:0] ITYPE = 7'b0010011, BR = 7'b1100011, JAL = 7'b1101111, LUI = 7'b0110111;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, mem_ready;
    logic       mem_req, mem_we, adr_src, ir_write, pc_write, reg_write, bus_err;
    logic [1:0] alu_src_a, alu_src_b, result_src;
    logic [2:0] imm_src, alu_ctrl;
    logic [18:0] obs;

    int checks = 0;
    int errors = 0;
    int instr_n = 0;
    logic err_m = 1'b0;

    logic        q_rdy[$];
    logic        q_zero[$];
    logic [18:0] q_exp[$];
    string       q_tag[$];

    multicycle_ctrl_fsm #(.ALUCTRL_W(3), .TIMEOUT_W(TW)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7b5(funct7b5), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .imm_src(imm_src), .alu_ctrl(alu_ctrl),
        .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    assign obs = {mem_req, mem_we, adr_src, ir_write, pc_write, reg_write,
                  alu_src_a, alu_src_b, result_src, imm_src, alu_ctrl, bus_err};

    task automatic check_eq(input string tag, input logic [18:0] got, input logic [18:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end
    endtask

    function automatic logic rb();
        return logic'($urandom_range(0, 1));
    endfunction

    // Field order: req we adr irw pcw rw | src_a src_b result_src imm alu | bus_err.
    function automatic logic [18:0] mk(input logic req, input logic we, input logic adr,
                                       input logic irw, input logic pcw, input logic rw,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [1:0] rs, input logic [2:0] imm,
                                       input logic [2:0] alu);
        return {req, we, adr, irw, pcw, rw, sa, sb, rs, imm, alu, err_m};
    endfunction

    function automatic logic [2:0] exp_alu(input logic [2:0] f3, input logic sub_ok);
        if (f3 == 3'd0) return sub_ok ? 3'b001 : 3'b000;
        if (f3 == 3'd2) return 3'b101;
        if (f3 == 3'd4) return 3'b100;
        if (f3 == 3'd6) return 3'b011;
        if (f3 == 3'd7) return 3'b010;
        return 3'b000;
    endfunction

    task automatic push(input logic r, input logic z, input logic [18:0] e, input string ph);
        q_rdy.push_back(r);
        q_zero.push_back(z);
        q_exp.push_back(e);
        q_tag.push_back($sformatf("%s#%0d", ph, instr_n));
    endtask

    // d idle cycles then ready; d >= TMAX idle cycles means the access times out.
    task automatic wait_phase(input string ph, input logic [18:0] idle, input logic [18:0] rdyv,
                              input int d, output bit ok);
        for (int i = 0; i < d && i < TMAX; i++) push(1'b0, rb(), idle, ph);
        if (d < TMAX) begin
            push(1'b1, rb(), rdyv, ph);
            ok = 1'b1;
        end else begin
            err_m = 1'b1;
            ok    = 1'b0;
        end
    endtask

    task automatic build_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                               input int df, input int dm, input logic zb);
        bit ok;
        logic st;
        logic [18:0] v;
        wait_phase("fetch", mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000),
                   mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,3'b000,3'b000), df, ok);
        if (!ok) wait_phase("refetch", mk(1,0,0,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000),
                            mk(1,0,0,1,1,0,2'b00,2'b10,2'b10,3'b000,3'b000), 0, ok);
        push(rb(), rb(), mk(0,0,0,0,0,0,2'b01,2'b01,2'b00,3'b010,3'b000), "decode");
        if (o == LOAD || o == STORE) begin
            st = (o == STORE);
            push(rb(), rb(), mk(0,0,0,0,0,0,2'b10,2'b01,2'b00,{2'b00, st},3'b000), "memadr");
            v = mk(1,st,1,0,0,0,2'b00,2'b00,2'b00,3'b000,3'b000);
            wait_phase(st ? "memwr" : "memrd", v, v, dm, ok);
            if (ok && !st) push(rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b01,3'b000,3'b000), "memwb");
        end else if (o == RTYPE || o == ITYPE) begin
            push(rb(), rb(), mk(0,0,0,0,0,0,2'b10,(o == ITYPE) ? 2'b01 : 2'b00,2'b00,3'b000,
                 exp_alu(f3, (o == RTYPE) && f7)), "exec");
            push(rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000), "aluwb");
        end else if (o == BR) begin
            push(rb(), zb, mk(0,0,0,0,(f3 == 3'd0) ? zb : ((f3 == 3'd1) ? ~zb : 1'b0),0,
                 2'b10,2'b00,2'b00,3'b000,3'b001), "branch");
        end else if (o == JAL || o == LUI) begin
            if (o == JAL) push(rb(), rb(), mk(0,0,0,0,1,0,2'b01,2'b10,2'b00,3'b000,3'b000), "jal");
            else          push(rb(), rb(), mk(0,0,0,0,0,0,2'b00,2'b01,2'b00,3'b100,3'b110), "lui");
            push(rb(), rb(), mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,3'b000,3'b000), "aluwb");
        end
    endtask

    // Called at a negedge; drives each queued cycle, checks #1 later, returns at a negedge.
    task automatic run_steps(input int n);
        int k = 0;
        while (q_exp.size() > 0 && (n < 0 || k < n)) begin
            mem_ready = q_rdy.pop_front();
            zero      = q_zero.pop_front();
            #1;
            check_eq(q_tag.pop_front(), obs, q_exp.pop_front());
            @(negedge clk);
            k++;
        end
    endtask

    task automatic do_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                            input int df, input int dm, input logic zb);
        op = o; funct3 = f3; funct7b5 = f7;
        instr_n++;
        build_instr(o, f3, f7, df, dm, zb);
        run_steps(-1);
    endtask

    initial begin
        logic [6:0] ops [0:7];
        logic [6:0] o;
        int sel, df, dm;
        ops = '{LOAD, STORE, RTYPE, ITYPE, BR, JAL, LUI, 7'b1111111};
        rst = 1'b1; op = ITYPE; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        check_eq("reset_outputs", obs, 19'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        do_instr(ITYPE, 3'd0, 1'b0, 0, 0, 1'b0);
        do_instr(RTYPE, 3'd0, 1'b1, 0, 0, 1'b0);
        do_instr(ITYPE, 3'd0, 1'b1, 1, 0, 1'b0);
        do_instr(RTYPE, 3'd7, 1'b0, 0, 0, 1'b0);
        do_instr(ITYPE, 3'd2, 1'b0, 2, 0, 1'b0);
        do_instr(BR, 3'd1, 1'b0, 0, 0, 1'b0);
        do_instr(BR, 3'd1, 1'b0, 0, 0, 1'b1);
        do_instr(BR, 3'd0, 1'b0, 0, 0, 1'b0);
        do_instr(BR, 3'd0, 1'b0, 0, 0, 1'b1);
        do_instr(BR, 3'd4, 1'b0, 0, 0, 1'b1);
        do_instr(LOAD, 3'd2, 1'b0, 0, 5, 1'b0);
        do_instr(STORE, 3'd2, 1'b0, 0, 6, 1'b0);
        do_instr(JAL, 3'd0, 1'b0, 0, 0, 1'b0);
        do_instr(LUI, 3'd0, 1'b0, 0, 0, 1'b0);
        do_instr(7'b1111111, 3'd0, 1'b0, 0, 0, 1'b0);
        do_instr(ITYPE, 3'd4, 1'b0, 0, 0, 1'b0);
        do_instr(LOAD, 3'd2, 1'b0, 0, 20, 1'b0);
        do_instr(ITYPE, 3'd6, 1'b0, 9, 0, 1'b0);

        // Abort a load in its memory wait with an asynchronous reset.
        op = LOAD; funct3 = 3'd2; funct7b5 = 1'b0;
        instr_n++;
        build_instr(LOAD, 3'd2, 1'b0, 0, 4, 1'b0);
        run_steps(5);
        q_rdy.delete(); q_zero.delete(); q_exp.delete(); q_tag.delete();
        mem_ready = 1'b1;
        rst = 1'b1;
        #1;
        check_eq("rst_mid_memrd", obs, 19'd0);
        @(negedge clk);
        rst = 1'b0;
        err_m = 1'b0;

        for (int i = 0; i < 150; i++) begin
            sel = $urandom_range(0, 8);
            o   = (sel == 8) ? 7'($urandom) : ops[sel];
            df  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 9);
            dm  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 9);
            do_instr(o, 3'($urandom), rb(), df, dm, rb());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
